spi_slave_rx: RTL and testbench

Synthesizable SPI slave that terminates the bus driven by our SPI master core (cs_n/sck/mosi in, miso out) and converts it to byte streams in the system clock domain. Received bytes are buffered in a small FIFO with a valid/ready output. Transmit bytes are fetched through a valid/ready input and shifted onto miso. It is the downstream consumer of every master burst (write and read) and the DUT for the master model's burst tests.

---
 rtl/spi_slave_rx.sv | 177 +++++++++++++++++
 tb/tb_spi_slave_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI slave: synchronized bus, receive FIFO with valid/ready, transmit fetch with valid/ready
module spi_slave_rx #(
    parameter int PHASE    = 0,
    parameter int ACTIVE   = 0,
    parameter int RX_DEPTH = 4
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] byte_cnt,
    output logic        frame_done,
    output logic        overflow,
    output logic        underrun
);
    localparam int   AW       = $clog2(RX_DEPTH);
    localparam logic SCK_IDLE = (ACTIVE != 0);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    logic [2:0]    cs_sync, sck_sync;
    logic [1:0]    mosi_sync, sync_fill;
    logic          armed;
    state_t        state;
    logic [2:0]    bit_cnt, tx_bit;
    logic [7:0]    rx_shift, tx_shift;
    logic          skip_lead;

    logic          cs_fall, cs_rise, sck_lead, sck_trail, sample_edge, shift_edge;
    logic [7:0]    fetch_byte, rx_wdata;
    logic          push, pop, push_ok;
    logic [7:0]    mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [AW:0]   count, after_pop, count_next;

    // armed only goes high once the synchronizer holds a real cs_n=1, so a
    // frame already running when reset is released is never picked up
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= 3'b111;
            sck_sync  <= {3{SCK_IDLE}};
            mosi_sync <= 2'b00;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[1:0], cs_n};
            sck_sync  <= {sck_sync[1:0], sck};
            mosi_sync <= {mosi_sync[0], mosi};
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & cs_sync[1]);
        end
    end

    always_comb begin
        cs_fall     = cs_sync[2] & ~cs_sync[1];
        cs_rise     = ~cs_sync[2] & cs_sync[1];
        sck_lead    = (sck_sync[2] == SCK_IDLE) && (sck_sync[1] != SCK_IDLE);
        sck_trail   = (sck_sync[2] != SCK_IDLE) && (sck_sync[1] == SCK_IDLE);
        sample_edge = (PHASE != 0) ? sck_trail : sck_lead;
        shift_edge  = (PHASE != 0) ? sck_lead : sck_trail;
        fetch_byte  = tx_valid ? tx_data : 8'hFF;
        rx_wdata    = {rx_shift[6:0], mosi_sync[1]};
        push        = (state == ST_ACTIVE) && !cs_rise && sample_edge && (bit_cnt == 3'd7);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            miso_oe    <= 1'b0;
            bit_cnt    <= 3'd0;
            tx_bit     <= 3'd0;
            rx_shift   <= 8'h00;
            tx_shift   <= 8'h00;
            skip_lead  <= 1'b0;
            byte_cnt   <= 16'h0000;
            tx_ready   <= 1'b0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_ready   <= 1'b0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall && armed) begin
                        state     <= ST_ACTIVE;
                        miso_oe   <= 1'b1;
                        bit_cnt   <= 3'd0;
                        tx_bit    <= 3'd0;
                        byte_cnt  <= 16'h0000;
                        skip_lead <= (PHASE != 0);
                        tx_shift  <= fetch_byte;
                        tx_ready  <= tx_valid;
                        underrun  <= ~tx_valid;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state      <= ST_IDLE;
                        miso_oe    <= 1'b0;
                        bit_cnt    <= 3'd0;
                        frame_done <= 1'b1;
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= rx_wdata;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7 && byte_cnt != 16'hFFFF)
                                byte_cnt <= byte_cnt + 16'd1;
                        end
                        // the leading edge that opens a PHASE=1 frame presents the MSB already loaded
                        if (shift_edge) begin
                            if (skip_lead) begin
                                skip_lead <= 1'b0;
                            end else if (tx_bit == 3'd7) begin
                                tx_bit   <= 3'd0;
                                tx_shift <= fetch_byte;
                                tx_ready <= tx_valid;
                                underrun <= ~tx_valid;
                            end else begin
                                tx_bit   <= tx_bit + 3'd1;
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign miso = miso_oe & tx_shift[7];

    // a write into a full FIFO still lands when the head is popped in the same cycle
    always_comb begin
        pop        = rx_valid & rx_ready;
        push_ok    = push && ((count != (AW+1)'(RX_DEPTH)) || pop);
        after_pop  = count - (AW+1)'(pop);
        count_next = after_pop + (AW+1)'(push_ok);
        rd_next    = rd_ptr + AW'(pop);
    end

    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr] <= rx_wdata;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            overflow <= push & ~push_ok;
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr   <= rd_next;
            count    <= count_next;
            rx_valid <= (count_next != '0);
            if (push_ok && after_pop == '0)
                rx_data <= rx_wdata;
            else if (after_pop != '0)
                rx_data <= mem[rd_next];
        end
    end
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - table-driven bench for spi_slave_rx in all four SPI modes
module tb_spi_slave_rx;
    logic        clock = 1'b0;
    logic        rst_n;
    logic [3:0]  cs_n, sck, miso, miso_oe, rx_valid, tx_ready, frame_done, overflow, underrun;
    logic        mosi, rx_ready, tx_valid;
    logic [7:0]  tx_data;
    logic [7:0]  rx_data [4];
    logic [15:0] byte_cnt [4];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_rx #(.PHASE(g % 2), .ACTIVE(g / 2), .RX_DEPTH(4)) dut (
            .clock(clock), .rst_n(rst_n), .cs_n(cs_n[g]), .sck(sck[g]), .mosi(mosi),
            .miso(miso[g]), .miso_oe(miso_oe[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
            .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready[g]),
            .byte_cnt(byte_cnt[g]), .frame_done(frame_done[g]), .overflow(overflow[g]),
            .underrun(underrun[g]));
    end

    typedef struct {
        int mode; int nbits; bit rdy; int ntx; int pat;
        int e_cnt; int e_ovf; int e_txr; int e_ur;
    } vec_t;

    vec_t       vt [10];
    int         checks, errors, cur;
    int         fd_n, ov_n, txr_n, ur_n, tx_n, tx_idx;
    logic [7:0] got [$];
    logic [7:0] sent [16];
    logic [7:0] txb [16];
    logic [7:0] mrd [16];
    logic [7:0] pat_bytes [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        if (rx_valid[cur] && rx_ready)
            got.push_back(rx_data[cur]);
        @(posedge clock);
        #2;
        if (frame_done[cur]) fd_n++;
        if (overflow[cur]) ov_n++;
        if (underrun[cur]) ur_n++;
        if (tx_ready[cur]) begin
            txr_n++;
            tx_idx++;
        end
        tx_valid = (tx_idx < tx_n);
        tx_data  = tx_valid ? txb[tx_idx] : 8'h00;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        fd_n = 0; ov_n = 0; txr_n = 0; ur_n = 0;
        got.delete();
    endtask

    // behavioural SPI master: 8 system clocks per sck half period
    task automatic xfer(input int m, input int nbits, input bit start_cs, input bit end_cs);
        logic cpol, cpha;
        cpol = (m / 2) != 0;
        cpha = (m % 2) != 0;
        if (start_cs) begin
            cs_n[m] = 1'b0;
            wait_n(8);
        end
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = sent[i / 8][7 - (i % 8)];
                wait_n(8);
                mrd[i / 8][7 - (i % 8)] = miso[m];
                sck[m] = ~cpol;
                wait_n(8);
                sck[m] = cpol;
            end else begin
                sck[m] = ~cpol;
                mosi = sent[i / 8][7 - (i % 8)];
                wait_n(8);
                mrd[i / 8][7 - (i % 8)] = miso[m];
                sck[m] = cpol;
                wait_n(8);
            end
        end
        if (end_cs) begin
            wait_n(8);
            cs_n[m] = 1'b1;
            wait_n(8);
        end
    endtask

    task automatic run_row(input int r);
        vec_t v;
        int   full, nexp;
        v = vt[r];
        cur = v.mode;
        clear_counts();
        rx_ready = v.rdy;
        tx_idx = 0;
        for (int k = 0; k < 16; k++) begin
            sent[k] = 8'($urandom_range(0, 255));
            txb[k]  = 8'($urandom_range(0, 255));
            mrd[k]  = 8'h00;
        end
        if (v.pat == 1) for (int k = 0; k < 9; k++) sent[k] = pat_bytes[k];
        if (v.pat == 2) begin txb[0] = 8'hA5; txb[1] = 8'h3C; txb[2] = 8'hC3; end
        if (v.pat == 3) begin sent[0] = 8'h5A; txb[0] = 8'h96; end
        tx_n = v.ntx;
        tx_valid = (tx_n > 0);
        tx_data = txb[0];
        xfer(cur, v.nbits, 1'b1, 1'b1);
        rx_ready = 1'b1;
        wait_n(8);

        full = v.nbits / 8;
        nexp = (v.rdy || full < 4) ? full : 4;
        check($sformatf("row%0d_byte_cnt", r), 32'(byte_cnt[cur]), 32'(v.e_cnt));
        check($sformatf("row%0d_frame_done", r), 32'(fd_n), 32'd1);
        check($sformatf("row%0d_overflow", r), 32'(ov_n), 32'(v.e_ovf));
        check($sformatf("row%0d_tx_ready", r), 32'(txr_n), 32'(v.e_txr));
        check($sformatf("row%0d_underrun", r), 32'(ur_n), 32'(v.e_ur));
        check($sformatf("row%0d_rx_count", r), 32'(got.size()), 32'(nexp));
        for (int k = 0; k < nexp && k < got.size(); k++)
            check($sformatf("row%0d_rx_byte%0d", r, k), 32'(got[k]), 32'(sent[k]));
        for (int k = 0; k < full; k++)
            check($sformatf("row%0d_miso_byte%0d", r, k), 32'(mrd[k]),
                  32'((k < v.ntx) ? txb[k] : 8'hFF));
        check($sformatf("row%0d_idle_oe", r), {31'd0, miso_oe[cur]}, 32'd0);
    endtask

    task automatic reset_seq();
        cur = 0;
        clear_counts();
        rx_ready = 1'b0;
        tx_n = 0; tx_idx = 0; tx_valid = 1'b0;
        for (int k = 0; k < 3; k++) sent[k] = 8'($urandom_range(0, 255));
        xfer(0, 12, 1'b1, 1'b0);
        check("pre_rst_rx_valid", {31'd0, rx_valid[0]}, 32'd1);
        check("pre_rst_byte_cnt", 32'(byte_cnt[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", {25'd0, miso[0], miso_oe[0], rx_valid[0], tx_ready[0],
              frame_done[0], overflow[0], underrun[0]}, 32'd0);
        check("mid_rst_byte_cnt", 32'(byte_cnt[0]), 32'd0);
        check("mid_rst_rx_data", 32'(rx_data[0]), 32'd0);
        wait_n(2);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        wait_n(2);
        clear_counts();
        xfer(0, 16, 1'b0, 1'b1);
        check("post_rst_ignored_cnt", 32'(byte_cnt[0]), 32'd0);
        check("post_rst_ignored_rx", 32'(got.size()), 32'd0);
        check("post_rst_no_done", 32'(fd_n), 32'd0);
        check("post_rst_no_fetch", 32'(txr_n + ur_n), 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0; cur = 0;
        fd_n = 0; ov_n = 0; txr_n = 0; ur_n = 0; tx_n = 0; tx_idx = 0;
        rst_n = 1'b0; cs_n = 4'b1111; sck = 4'b1100; mosi = 1'b0;
        rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        pat_bytes = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        //        mode nbits rdy ntx pat cnt ovf txr ur
        vt[0] = '{0, 72, 1, 0, 1, 9, 0, 0, 10};
        vt[1] = '{0, 32, 1, 3, 2, 4, 0, 3, 2};
        vt[2] = '{1,  8, 1, 1, 3, 1, 0, 1, 0};
        vt[3] = '{2,  8, 1, 1, 3, 1, 0, 1, 1};
        vt[4] = '{3,  8, 1, 1, 3, 1, 0, 1, 0};
        vt[5] = '{0, 48, 0, 0, 0, 6, 2, 0, 7};
        vt[6] = '{0, 13, 1, 2, 0, 1, 0, 2, 0};
        vt[7] = '{0, 16, 1, 0, 0, 2, 0, 0, 3};
        vt[8] = '{3, 24, 1, 2, 0, 3, 0, 2, 1};
        vt[9] = '{2, 24, 1, 3, 0, 3, 0, 3, 1};

        repeat (3) @(posedge clock);
        #2;
        for (int m = 0; m < 4; m++) begin
            check($sformatf("reset_flags%0d", m), {25'd0, miso[m], miso_oe[m], rx_valid[m],
                  tx_ready[m], frame_done[m], overflow[m], underrun[m]}, 32'd0);
            check($sformatf("reset_rx_data%0d", m), 32'(rx_data[m]), 32'd0);
            check($sformatf("reset_byte_cnt%0d", m), 32'(byte_cnt[m]), 32'd0);
        end
        rst_n = 1'b1;
        wait_n(4);

        for (int i = 0; i < 10; i++) begin
            if (i == 7) reset_seq();
            run_row(i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
